// File: rtl/j_pixel_indexer_if.sv
// Control/index bus between the buffer controller (master) and the pixel indexer (slave).
interface j_pixel_indexer_if #(
    parameter int unsigned CNT_W  = 13,
    parameter int unsigned ADDR_W = 26
);
    logic              clear;
    logic              start;
    logic              mode;
    logic [CNT_W-1:0]  img_width;
    logic [CNT_W-1:0]  img_height;
    logic              advance;
    logic              valid;
    logic [CNT_W-1:0]  col;
    logic [CNT_W-1:0]  row;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              row_end;
    logic              blk_end;
    logic              frame_done;
    logic              cfg_err;

    modport master (
        output clear, start, mode, img_width, img_height, advance,
        input  valid, col, row, addr, last, row_end, blk_end, frame_done, cfg_err
    );

    modport slave (
        input  clear, start, mode, img_width, img_height, advance,
        output valid, col, row, addr, last, row_end, blk_end, frame_done, cfg_err
    );
endinterface

// File: rtl/j_pixel_indexer.sv
// 2D pixel address generator: raster or BLKxBLK block traversal, one index per accepted advance.
// The linear address is tracked incrementally so no multiplier is needed.
module j_pixel_indexer #(
    parameter int unsigned CNT_W    = 13,
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned BLK_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst,
    j_pixel_indexer_if.slave   bus
);
    localparam int unsigned          BLK     = 1 << BLK_LOG2;
    localparam logic [CNT_W-1:0]     BLK_M1  = CNT_W'(BLK - 1);
    localparam logic [BLK_LOG2-1:0]  OFF_MAX = '1;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   width_q, width_d;
    logic [CNT_W-1:0]   height_q, height_d;
    logic [ADDR_W-1:0]  wstep_q, wstep_d;

    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               last_q, last_d;
    logic               row_end_q, row_end_d;
    logic               blk_end_q, blk_end_d;
    logic               frame_done_q, frame_done_d;
    logic               cfg_err_q, cfg_err_d;

    logic               cfg_ok_c;
    logic               start_ok_c;
    logic [CNT_W-1:0]   w_last_c;

    // Block mode additionally needs both dimensions to be whole blocks.
    assign cfg_ok_c   = (bus.img_width != '0) && (bus.img_height != '0) &&
                        (!bus.mode || ((bus.img_width[BLK_LOG2-1:0] == '0) &&
                                       (bus.img_height[BLK_LOG2-1:0] == '0)));
    assign start_ok_c = (state_q == S_IDLE) && !bus.clear && bus.start && cfg_ok_c;
    assign w_last_c   = width_q - CNT_W'(1);

    // State and register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            width_q      <= '0;
            height_q     <= '0;
            wstep_q      <= '0;
            valid_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            last_q       <= 1'b0;
            row_end_q    <= 1'b0;
            blk_end_q    <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            width_q      <= width_d;
            height_q     <= height_d;
            wstep_q      <= wstep_d;
            valid_q      <= valid_d;
            col_q        <= col_d;
            row_q        <= row_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            row_end_q    <= row_end_d;
            blk_end_q    <= blk_end_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Next state and configuration latch
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        width_d  = width_q;
        height_d = height_q;
        wstep_d  = wstep_q;
        if (bus.clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok_c) begin
                        state_d  = S_RUN;
                        mode_d   = bus.mode;
                        width_d  = bus.img_width;
                        height_d = bus.img_height;
                        // (BLK-1)*W used by the jump back to the top of the next block
                        wstep_d  = (ADDR_W'(bus.img_width) << BLK_LOG2) - ADDR_W'(bus.img_width);
                    end
                end
                S_RUN: begin
                    if (bus.advance && last_q) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Index stepping and status flags
    always_comb begin
        valid_d      = valid_q;
        col_d        = col_q;
        row_d        = row_q;
        addr_d       = addr_q;
        frame_done_d = 1'b0;
        cfg_err_d    = 1'b0;
        if (bus.clear) begin
            valid_d = 1'b0;
            col_d   = '0;
            row_d   = '0;
            addr_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cfg_err_d = bus.start && !cfg_ok_c;
                    if (start_ok_c) begin
                        valid_d = 1'b1;
                        col_d   = '0;
                        row_d   = '0;
                        addr_d  = '0;
                    end
                end
                S_RUN: begin
                    if (bus.advance) begin
                        if (last_q) begin
                            valid_d      = 1'b0;
                            col_d        = '0;
                            row_d        = '0;
                            addr_d       = '0;
                            frame_done_d = 1'b1;
                        end else if (!mode_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (col_q == w_last_c) begin
                                col_d = '0;
                                row_d = row_q + CNT_W'(1);
                            end else begin
                                col_d = col_q + CNT_W'(1);
                            end
                        end else if (col_q[BLK_LOG2-1:0] != OFF_MAX) begin
                            col_d  = col_q + CNT_W'(1);
                            addr_d = addr_q + ADDR_W'(1);
                        end else if (row_q[BLK_LOG2-1:0] != OFF_MAX) begin
                            col_d  = col_q - BLK_M1;
                            row_d  = row_q + CNT_W'(1);
                            addr_d = addr_q + ADDR_W'(width_q) - ADDR_W'(BLK_M1);
                        end else if (col_q != w_last_c) begin
                            col_d  = col_q + CNT_W'(1);
                            row_d  = row_q - BLK_M1;
                            addr_d = addr_q - wstep_q + ADDR_W'(1);
                        end else begin
                            col_d  = '0;
                            row_d  = row_q + CNT_W'(1);
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: valid_d = 1'b0;
            endcase
        end
        last_d    = valid_d && (row_d == height_d - CNT_W'(1)) && (col_d == width_d - CNT_W'(1));
        row_end_d = valid_d && (mode_d ? (col_d[BLK_LOG2-1:0] == OFF_MAX)
                                       : (col_d == width_d - CNT_W'(1)));
        blk_end_d = valid_d && mode_d && (col_d[BLK_LOG2-1:0] == OFF_MAX) &&
                    (row_d[BLK_LOG2-1:0] == OFF_MAX);
    end

    assign bus.valid      = valid_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.addr       = addr_q;
    assign bus.last       = last_q;
    assign bus.row_end    = row_end_q;
    assign bus.blk_end    = blk_end_q;
    assign bus.frame_done = frame_done_q;
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_j_pixel_indexer.sv
// Self-checking bench for j_pixel_indexer: randomized frames and stalls against an arithmetic index model.
module tb_j_pixel_indexer;
    localparam int unsigned CW = 13;
    localparam int unsigned AW = 26;
    localparam int unsigned VW = 1 + CW + CW + AW + 5;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    j_pixel_indexer_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

    j_pixel_indexer #(.CNT_W(CW), .ADDR_W(AW), .BLK_LOG2(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observed();
        return {bus.valid, bus.col, bus.row, bus.addr, bus.last, bus.row_end,
                bus.blk_end, bus.frame_done, bus.cfg_err};
    endfunction

    function automatic logic [VW-1:0] idle_vec(input bit fd, input bit ce);
        return {1'b0, CW'(0), CW'(0), AW'(0), 3'b000, fd, ce};
    endfunction

    // Index i of a frame, derived from traversal order: raster row-major, or block by block.
    function automatic logic [VW-1:0] model_vec(input bit md, input int w, input int h, input int i);
        int col, row, xo, yo, rem;
        bit lst, re, be;
        if (!md) begin
            col = i % w;
            row = i / w;
            xo  = 0;
            yo  = 0;
        end else begin
            rem = i % (8 * w);
            xo  = (rem % 64) % 8;
            yo  = (rem % 64) / 8;
            col = (rem / 64) * 8 + xo;
            row = (i / (8 * w)) * 8 + yo;
        end
        lst = (i == w * h - 1);
        re  = md ? (xo == 7) : (col == w - 1);
        be  = md && (xo == 7) && (yo == 7);
        return {1'b1, CW'(col), CW'(row), AW'(row * w + col), lst, re, be, 1'b0, 1'b0};
    endfunction

    // pat: 0 = advance always, 1 = random stalls, 2 = repeating 1,0,0,1
    task automatic run_frame(input bit md, input int w, input int h, input int pat);
        int i, n, cyc;
        bit adv;
        logic [VW-1:0] exp_v, got;
        n   = w * h;
        i   = 0;
        cyc = 0;
        bus.mode       = md;
        bus.img_width  = CW'(w);
        bus.img_height = CW'(h);
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        while (i < n && cyc < 4000) begin
            exp_v = model_vec(md, w, h, i);
            got   = observed();
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL frame md=%0d %0dx%0d idx=%0d got=%h want=%h", md, w, h, i, got, exp_v);
            end
            case (pat)
                0:       adv = 1'b1;
                1:       adv = ($urandom_range(99) >= 40);
                default: adv = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            bus.advance = adv;
            // Start and config jitter during a run must be ignored.
            if (pat != 0 && !(adv && i == n - 1)) begin
                bus.start      = 1'($urandom_range(1));
                bus.img_width  = CW'($urandom_range(40));
                bus.mode       = 1'($urandom_range(1));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            if (adv) i++;
            cyc++;
        end
        bus.advance = 1'b0;
        bus.start   = 1'b0;
        if (i < n) begin
            bad++;
            total++;
            $display("FAIL frame_timeout md=%0d %0dx%0d got_idx=%0d want_idx=%0d", md, w, h, i, n);
        end
        got = observed();
        total++;
        if (got !== idle_vec(1'b1, 1'b0)) begin
            bad++;
            $display("FAIL frame_done_pulse got=%h want=%h", got, idle_vec(1'b1, 1'b0));
        end
        @(posedge clk); #1;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL frame_done_clear got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] got;
        rst = 1'b1;
        bus.clear = 1'b0; bus.start = 1'b0; bus.mode = 1'b0;
        bus.img_width = '0; bus.img_height = '0; bus.advance = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL after_reset got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
    endtask

    task automatic test_raster();
        run_frame(1'b0, 4, 3, 0);
    endtask

    task automatic test_block();
        run_frame(1'b1, 16, 16, 0);
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 4, 3, 2);
    endtask

    task automatic test_cfg_err();
        logic [VW-1:0] got;
        bus.mode = 1'b1; bus.img_width = CW'(12); bus.img_height = CW'(16); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b1)) begin
            bad++;
            $display("FAIL cfg_err_block got=%h want=%h", got, idle_vec(1'b0, 1'b1));
        end
        @(posedge clk); #1;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL cfg_err_pulse_end got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
        bus.mode = 1'b0; bus.img_width = '0; bus.img_height = CW'(3); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b1)) begin
            bad++;
            $display("FAIL cfg_err_zero_w got=%h want=%h", got, idle_vec(1'b0, 1'b1));
        end
        @(posedge clk); #1;
        run_frame(1'b0, 4, 3, 0);
    endtask

    task automatic test_clear();
        logic [VW-1:0] got;
        bus.mode = 1'b0; bus.img_width = CW'(4); bus.img_height = CW'(3); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.advance = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.advance = 1'b0;
        got = observed();
        total++;
        if (got !== model_vec(1'b0, 4, 3, 5)) begin
            bad++;
            $display("FAIL clear_pre_idx5 got=%h want=%h", got, model_vec(1'b0, 4, 3, 5));
        end
        bus.clear = 1'b1; bus.advance = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.advance = 1'b0;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL clear_abort got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
        bus.clear = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.clear = 1'b0; bus.start = 1'b0;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL clear_beats_start got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
    endtask

    task automatic test_async_reset();
        logic [VW-1:0] got;
        bus.mode = 1'b0; bus.img_width = CW'(4); bus.img_height = CW'(3); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.advance = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        bus.advance = 1'b0;
        rst = 1'b1;
        #1;
        got = observed();
        total++;
        if (got !== idle_vec(1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset got=%h want=%h", got, idle_vec(1'b0, 1'b0));
        end
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        run_frame(1'b0, 4, 3, 0);
        run_frame(1'b0, 1, 1, 0);
    endtask

    task automatic test_random();
        bit md;
        int w, h;
        for (int k = 0; k < 8; k++) begin
            md = 1'($urandom_range(1));
            if (md) begin
                w = 8 * $urandom_range(1, 3);
                h = 8 * $urandom_range(1, 2);
            end else begin
                w = $urandom_range(1, 9);
                h = $urandom_range(1, 6);
            end
            run_frame(md, w, h, 1);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_raster();
        test_block();
        test_backpressure();
        test_cfg_err();
        test_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
